// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment bit order and hex glyph table
// Purpose: single source of truth for segment bit positions and the 16 hex
//          glyphs, used by both the hex-to-segment encoder and the reader.
// Ports:   none (package).
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Segment bit positions within seg_t, {a,b,c,d,e,f,g} with a at bit 6.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam seg_t SEG_M_A = seg_t'(1 << SEG_A);
    localparam seg_t SEG_M_B = seg_t'(1 << SEG_B);
    localparam seg_t SEG_M_C = seg_t'(1 << SEG_C);
    localparam seg_t SEG_M_D = seg_t'(1 << SEG_D);
    localparam seg_t SEG_M_E = seg_t'(1 << SEG_E);
    localparam seg_t SEG_M_F = seg_t'(1 << SEG_F);
    localparam seg_t SEG_M_G = seg_t'(1 << SEG_G);

    // Glyphs spelled out by lit segments so the table reads like the display.
    localparam seg_t SEG_HEX_0 = SEG_M_A | SEG_M_B | SEG_M_C | SEG_M_D | SEG_M_E | SEG_M_F;
    localparam seg_t SEG_HEX_1 = SEG_M_B | SEG_M_C;
    localparam seg_t SEG_HEX_2 = SEG_M_A | SEG_M_B | SEG_M_D | SEG_M_E | SEG_M_G;
    localparam seg_t SEG_HEX_3 = SEG_M_A | SEG_M_B | SEG_M_C | SEG_M_D | SEG_M_G;
    localparam seg_t SEG_HEX_4 = SEG_M_B | SEG_M_C | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_5 = SEG_M_A | SEG_M_C | SEG_M_D | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_6 = SEG_M_A | SEG_M_C | SEG_M_D | SEG_M_E | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_7 = SEG_M_A | SEG_M_B | SEG_M_C;
    localparam seg_t SEG_HEX_8 = SEG_M_A | SEG_M_B | SEG_M_C | SEG_M_D | SEG_M_E | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_9 = SEG_M_A | SEG_M_B | SEG_M_C | SEG_M_D | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_A = SEG_M_A | SEG_M_B | SEG_M_C | SEG_M_E | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_B = SEG_M_C | SEG_M_D | SEG_M_E | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_C = SEG_M_A | SEG_M_D | SEG_M_E | SEG_M_F;
    localparam seg_t SEG_HEX_D = SEG_M_B | SEG_M_C | SEG_M_D | SEG_M_E | SEG_M_G;
    localparam seg_t SEG_HEX_E = SEG_M_A | SEG_M_D | SEG_M_E | SEG_M_F | SEG_M_G;
    localparam seg_t SEG_HEX_F = SEG_M_A | SEG_M_E | SEG_M_F | SEG_M_G;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational seven-segment glyph to hex nibble decoder
// Purpose: map a segment pattern back to its hex digit; any pattern that is
//          not one of the 16 glyphs is flagged invalid and decodes to 0.
// Ports:   seg_i     - segment pattern {a..g}
//          nibble_o  - decoded hex value
//          invalid_o - pattern is not a hex glyph
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       invalid_o
);

    always_comb begin
        nibble_o  = 4'h0;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_HEX_0: nibble_o = 4'h0;
            SEG_HEX_1: nibble_o = 4'h1;
            SEG_HEX_2: nibble_o = 4'h2;
            SEG_HEX_3: nibble_o = 4'h3;
            SEG_HEX_4: nibble_o = 4'h4;
            SEG_HEX_5: nibble_o = 4'h5;
            SEG_HEX_6: nibble_o = 4'h6;
            SEG_HEX_7: nibble_o = 4'h7;
            SEG_HEX_8: nibble_o = 4'h8;
            SEG_HEX_9: nibble_o = 4'h9;
            SEG_HEX_A: nibble_o = 4'hA;
            SEG_HEX_B: nibble_o = 4'hB;
            SEG_HEX_C: nibble_o = 4'hC;
            SEG_HEX_D: nibble_o = 4'hD;
            SEG_HEX_E: nibble_o = 4'hE;
            SEG_HEX_F: nibble_o = 4'hF;
            default:   invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// rtl/seg_reader.sv - scanned seven-segment display reader / word assembler
// Purpose: watch a multiplexed display bus, capture each digit once its
//          pattern has been stable for STABLE_CYCLES cycles, and publish the
//          assembled word once every digit has been seen.
// Ports:   clk, rst  - clock, synchronous active-high reset
//          an_i      - one-hot digit select (bit k = digit k)
//          seg_i     - shared segment lines {a..g}
//          value_o   - last complete word, digit k in [4k+3:4k]
//          valid_o   - one-cycle pulse when value_o updates
//          bad_o     - some digit of that frame was not a hex glyph
module seg_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_i,
    input  logic [6:0]            seg_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic                  valid_o,
    output logic                  bad_o
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAP_AT  = 8'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0]   prev_an_q,  prev_an_d;
    logic [6:0]          prev_seg_q, prev_seg_d;
    logic [7:0]          cnt_q,      cnt_d;
    logic                flag_q,     flag_d;
    logic [DIGITS-1:0]   mask_q,     mask_d;
    logic [DIGITS-1:0]   bad_q,      bad_d;
    logic [4*DIGITS-1:0] slots_q,    slots_d;
    logic [4*DIGITS-1:0] value_q,    value_d;
    logic                bad_out_q,  bad_out_d;
    logic                valid_q,    valid_d;

    logic       onehot;
    logic       same;
    logic       flag_base;
    logic       capture;
    logic [3:0] dec_nibble;
    logic       dec_invalid;

    seg7_to_hex u_dec (
        .seg_i     (seg_i),
        .nibble_o  (dec_nibble),
        .invalid_o (dec_invalid)
    );

    always_comb begin
        prev_an_d  = an_i;
        prev_seg_d = seg_i;
        onehot     = $onehot(an_i);
        same       = onehot && (an_i == prev_an_q) && (seg_i == prev_seg_q);

        // Any change or a non-one-hot select opens a fresh stability window.
        if (same) begin
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
            flag_base = flag_q;
        end else begin
            cnt_d     = 8'd0;
            flag_base = 1'b0;
        end

        // Counter value for this cycle equals STABLE_CYCLES-1 on the
        // STABLE_CYCLES-th identical sample; the flag limits it to one capture.
        capture = onehot && (cnt_d == CAP_AT) && !flag_base;
        flag_d  = flag_base | capture;

        mask_d    = mask_q;
        bad_d     = bad_q;
        slots_d   = slots_q;
        value_d   = value_q;
        bad_out_d = bad_out_q;
        valid_d   = 1'b0;

        // Publish first so a capture in this same cycle lands in the new frame.
        if (&mask_q) begin
            value_d   = slots_q;
            bad_out_d = |bad_q;
            valid_d   = 1'b1;
            mask_d    = '0;
            bad_d     = '0;
        end

        if (capture) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (an_i[k]) begin
                    slots_d[4*k +: 4] = dec_nibble;
                    mask_d[k]         = 1'b1;
                    bad_d[k]          = dec_invalid;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_an_q  <= '0;
            prev_seg_q <= '0;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            mask_q     <= '0;
            bad_q      <= '0;
            slots_q    <= '0;
            value_q    <= '0;
            bad_out_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            prev_an_q  <= prev_an_d;
            prev_seg_q <= prev_seg_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            mask_q     <= mask_d;
            bad_q      <= bad_d;
            slots_q    <= slots_d;
            value_q    <= value_d;
            bad_out_q  <= bad_out_d;
            valid_q    <= valid_d;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;
    assign bad_o   = bad_out_q;

endmodule

// File: tb/tb_seg_reader.sv
// tb/tb_seg_reader.sv - randomized self-checking bench for seg_reader
module tb_seg_reader;

    localparam int S = 4;

    typedef struct {
        int         cyc;
        bit         rst;
        logic [3:0] an;
        logic [6:0] seg;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic        bad;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an_i = 4'h0;
    logic [6:0]  seg_i = 7'h00;
    logic [15:0] value_o;
    logic        valid_o;
    logic        bad_o;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t log_q[$];
    ev_t  dut_q[$];
    ev_t  exp_q[$];
    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_reader #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .an_i    (an_i),
        .seg_i   (seg_i),
        .value_o (value_o),
        .valid_o (valid_o),
        .bad_o   (bad_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o === 1'b1) dut_q.push_back('{cyc, value_o, bad_o});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [3:0] an, input logic [6:0] seg);
        @(posedge clk);
        #1;
        rst   = r;
        an_i  = an;
        seg_i = seg;
        log_q.push_back('{cyc, r, an, seg});
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) drive(1'b0, an, seg);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive(1'b1, 4'h0, 7'h00);
    endtask

    task automatic frame(input logic [15:0] digits);
        for (int k = 0; k < 4; k++) hold(4'(1 << k), tbl[digits[4*k +: 4]], 6);
    endtask

    task automatic expect_pulses(input string tag, input int base, input int n,
                                 input logic [15:0] val, input logic bad);
        check({tag, "_count"}, dut_q.size() - base, n);
        if (dut_q.size() == base + n && n > 0) begin
            check({tag, "_value"}, dut_q[$].val, val);
            check({tag, "_bad"}, dut_q[$].bad, bad);
        end
    endtask

    // Reference: a capture is the S-th consecutive identical one-hot sample;
    // the cycle after all four digits are held, the word is published and is
    // visible one cycle later; a capture in the publish cycle starts a new frame.
    task automatic run_model();
        int          run = 0;
        bit          have_prev = 0;
        logic [3:0]  p_an = 0;
        logic [6:0]  p_seg = 0;
        logic [3:0]  mask = 0;
        logic [3:0]  badb = 0;
        logic [15:0] slots = 0;
        int          complete_at = -1;
        exp_q.delete();
        foreach (log_q[i]) begin
            ent_t e = log_q[i];
            if (e.rst) begin
                mask = 0; badb = 0; complete_at = -1; have_prev = 0; run = 0;
                continue;
            end
            if (complete_at == e.cyc) begin
                exp_q.push_back('{e.cyc + 1, slots, |badb});
                mask = 0; badb = 0; complete_at = -1;
            end
            if (have_prev && e.an == p_an && e.seg == p_seg) run++;
            else run = 1;
            have_prev = 1; p_an = e.an; p_seg = e.seg;
            if ($countones(e.an) == 1 && run == S) begin
                int   k = 0;
                logic [3:0] nib = 0;
                logic inv = 1;
                for (int j = 0; j < 4; j++) if (e.an[j]) k = j;
                for (int h = 0; h < 16; h++) if (tbl[h] == e.seg) begin nib = 4'(h); inv = 0; end
                slots[4*k +: 4] = nib;
                mask[k] = 1'b1;
                badb[k] = inv;
                if (mask == 4'hF) complete_at = e.cyc + 1;
            end
        end
    endtask

    initial begin
        int base;
        do_reset(3);
        hold(4'h0, 7'h00, 2);
        @(negedge clk);
        check("reset_value", value_o, 16'h0);
        check("reset_valid", valid_o, 1'b0);
        check("reset_bad", bad_o, 1'b0);

        base = dut_q.size();
        frame(16'h4321);
        hold(4'h0, 7'h00, 4);
        expect_pulses("scan_4321", base, 1, 16'h4321, 1'b0);

        base = dut_q.size();
        hold(4'b0001, 7'h7E, 20);
        hold(4'b0010, 7'h4F, 6);
        hold(4'b0100, 7'h47, 6);
        hold(4'b1000, 7'h77, 6);
        hold(4'h0, 7'h00, 4);
        expect_pulses("long_hold", base, 1, 16'hAFE0, 1'b0);

        base = dut_q.size();
        hold(4'b0001, tbl[1], 6);
        hold(4'b0010, tbl[2], 6);
        for (int i = 0; i < 8; i++) hold(4'b0100, tbl[2 + (i % 2)], 2);
        hold(4'b1000, tbl[7], 6);
        hold(4'h0, 7'h00, 4);
        check("glitch_none", dut_q.size() - base, 0);
        hold(4'b0100, tbl[9], 6);
        hold(4'h0, 7'h00, 4);
        expect_pulses("glitch_done", base, 1, 16'h7921, 1'b0);

        base = dut_q.size();
        hold(4'b0001, tbl[5], 6);
        hold(4'b0010, 7'h7C, 6);
        hold(4'b0100, tbl[6], 6);
        hold(4'b1000, tbl[7], 6);
        hold(4'h0, 7'h00, 4);
        expect_pulses("invalid", base, 1, 16'h7605, 1'b1);

        base = dut_q.size();
        hold(4'b0011, 7'h7E, 10);
        hold(4'b0000, 7'h7E, 10);
        hold(4'b1111, 7'h30, 10);
        check("not_onehot", dut_q.size() - base, 0);
        check("hold_value", value_o, 16'h7605);
        check("hold_bad", bad_o, 1'b1);

        base = dut_q.size();
        hold(4'b0001, tbl[1], 6);
        hold(4'b0010, tbl[2], 6);
        hold(4'b0100, tbl[3], 6);
        do_reset(2);
        @(negedge clk);
        check("midreset_value", value_o, 16'h0);
        frame(16'h8765);
        hold(4'h0, 7'h00, 4);
        expect_pulses("after_reset", base, 1, 16'h8765, 1'b0);

        base = dut_q.size();
        frame(16'h4321);
        frame(16'h8765);
        hold(4'h0, 7'h00, 4);
        check("b2b_count", dut_q.size() - base, 2);
        if (dut_q.size() == base + 2) begin
            check("b2b_first", dut_q[base].val, 16'h4321);
            check("b2b_second", dut_q[base + 1].val, 16'h8765);
        end

        for (int i = 0; i < 160; i++) begin
            logic [3:0] an;
            logic [6:0] seg;
            int r = $urandom_range(0, 19);
            if ($urandom_range(0, 49) == 0) do_reset(1);
            if (r == 0) an = 4'h0;
            else if (r == 1) an = 4'($urandom_range(0, 15)) | 4'b0011;
            else an = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) seg = 7'($urandom_range(0, 127));
            else seg = tbl[$urandom_range(0, 15)];
            hold(an, seg, $urandom_range(1, 7));
        end
        hold(4'h0, 7'h00, 6);

        run_model();
        check("model_count", dut_q.size(), exp_q.size());
        for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("ev%0d_cyc", i), dut_q[i].cyc, exp_q[i].cyc);
            check($sformatf("ev%0d_val", i), dut_q[i].val, exp_q[i].val);
            check($sformatf("ev%0d_bad", i), dut_q[i].bad, exp_q[i].bad);
        end
        if (exp_q.size() > 0) check("final_hold", value_o, exp_q[$].val);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
